fir_out_checker: RTL and testbench

Self-checking receiver at the output end of the FIR datapath: it consumes the filter's DOUT/VOUT stream and compares each valid sample against golden values preloaded through a write port. It keeps sample and error counts, records the index of the first mismatch, and raises DONE after a programmed number of samples. It sits where the bench data sink sits today, so an on-chip or emulation build can check the filter in hardware.

---
 rtl/fir_chk_pkg.sv | 15 +
 rtl/fir_out_checker_if.sv | 29 ++
 rtl/fir_chk_fifo.sv | 55 +++++
 rtl/fir_out_checker.sv | 127 ++++++++++++
 tb/tb_fir_out_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_chk_pkg.sv
// fir_out_checker shared types and constants.
// State encoding and 16-bit counter limits.
package fir_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int          CNT_W      = 16;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;
    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

endpackage

// File: rtl/fir_out_checker_if.sv
// Golden-write and sample-stream bundle for fir_out_checker.
// master drives stimulus; slave is the checker.
interface fir_out_checker_if #(
    parameter int DW = 8
);

    logic          EXP_VALID;
    logic [DW-1:0] EXP_DATA;
    logic          EXP_READY;
    logic          VIN;
    logic [DW-1:0] DIN;

    modport master (
        output EXP_VALID,
        output EXP_DATA,
        output VIN,
        output DIN,
        input  EXP_READY
    );

    modport slave (
        input  EXP_VALID,
        input  EXP_DATA,
        input  VIN,
        input  DIN,
        output EXP_READY
    );

endinterface

// File: rtl/fir_chk_fifo.sv
// Golden-sample FIFO: synchronous, reset to empty.
// No bypass; head is read combinationally.
module fir_chk_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        dout  = mem[rd_ptr];
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/fir_out_checker.sv
// Hardware sink for the FIR output: compares each valid sample
// against preloaded golden values and keeps error statistics.
module fir_out_checker
    import fir_chk_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int NSAMP = 64,
    parameter int TOL   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    fir_out_checker_if.slave bus,
    output logic             MISMATCH,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] SAMP_CNT,
    output logic [CNT_W-1:0] FIRST_ERR_IDX,
    output logic             UNDERRUN,
    output logic             OVERFLOW,
    output logic             DONE
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] TOL_U = 32'(TOL);

    state_t st_q;
    state_t st_d;

    logic          full;
    logic          empty;
    logic [AW:0]   occ;
    logic [DW-1:0] head;

    logic             run_en;
    logic             exp_ready;
    logic             push;
    logic             check;
    logic             pop;
    logic [DW:0]      diff;
    logic [DW:0]      mag;
    logic             fail;
    logic [CNT_W-1:0] samp_nxt;
    logic             last;

    fir_chk_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (bus.EXP_DATA),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE:    if (START) st_d = RUN;
            RUN:     if (check && last) st_d = fir_chk_pkg::DONE;
            default: st_d = st_q;
        endcase
    end

    always_comb begin
        run_en        = (st_q == RUN);
        exp_ready     = !full && (st_q != fir_chk_pkg::DONE);
        DONE          = (st_q == fir_chk_pkg::DONE);
        bus.EXP_READY = exp_ready;
    end

    // A same-cycle pop never frees a slot for the write: ready uses pre-pop fullness.
    always_comb begin
        push     = bus.EXP_VALID && exp_ready;
        check    = run_en && bus.VIN;
        pop      = check && !empty;
        diff     = {bus.DIN[DW-1], bus.DIN} - {head[DW-1], head};
        mag      = diff[DW] ? -diff : diff;
        fail     = empty || (32'(mag) > TOL_U);
        samp_nxt = SAMP_CNT + CNT_W'(1);
        last     = (samp_nxt == CNT_W'(NSAMP));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MISMATCH      <= 1'b0;
            ERR_CNT       <= '0;
            SAMP_CNT      <= '0;
            FIRST_ERR_IDX <= NO_ERR_IDX;
            UNDERRUN      <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            MISMATCH <= check && fail;
            if (check) begin
                SAMP_CNT <= samp_nxt;
                if (fail) begin
                    if (ERR_CNT != CNT_MAX) begin
                        ERR_CNT <= ERR_CNT + CNT_W'(1);
                    end
                    if (FIRST_ERR_IDX == NO_ERR_IDX) begin
                        FIRST_ERR_IDX <= SAMP_CNT;
                    end
                end
                if (empty) begin
                    UNDERRUN <= 1'b1;
                end
            end
            if (bus.EXP_VALID && !exp_ready) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_checker.sv
// Bench for fir_out_checker: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fir_out_checker;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NSAMP = 4;
    localparam int TOL   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mismatch;
    logic        underrun;
    logic        overflow;
    logic        done;
    logic [15:0] err_cnt;
    logic [15:0] samp_cnt;
    logic [15:0] first_err_idx;

    int checks = 0;
    int failures = 0;

    int m_q[$];
    bit m_run, m_done, m_mis, m_und, m_ovf;
    int m_err, m_samp, m_first;

    fir_out_checker_if #(.DW(DW)) bus ();

    fir_out_checker #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .NSAMP (NSAMP),
        .TOL   (TOL)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .START         (start),
        .bus           (bus),
        .MISMATCH      (mismatch),
        .ERR_CNT       (err_cnt),
        .SAMP_CNT      (samp_cnt),
        .FIRST_ERR_IDX (first_err_idx),
        .UNDERRUN      (underrun),
        .OVERFLOW      (overflow),
        .DONE          (done)
    );

    always #5 clk = ~clk;

    function automatic int sx(input int x);
        logic [7:0] b;
        b = 8'(x);
        return int'($signed(b));
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_run = 0; m_done = 0; m_mis = 0; m_und = 0; m_ovf = 0;
        m_err = 0; m_samp = 0; m_first = 65535;
    endfunction

    function automatic bit m_ready();
        return (m_q.size() < DEPTH) && !m_done;
    endfunction

    // Apply inputs for one edge, advance the model, land #1 after the edge.
    task automatic cyc(input bit s, input bit ev, input int ed,
                       input bit v, input int dn, input bit r);
        bit rdy, chk, fl;
        int e, d;
        start = s; rst = r;
        bus.EXP_VALID = ev; bus.EXP_DATA = 8'(ed);
        bus.VIN = v; bus.DIN = 8'(dn);
        if (r) begin
            model_reset();
        end else begin
            rdy = m_ready();
            chk = m_run && v;
            fl = 0;
            if (chk) begin
                if (m_q.size() == 0) begin
                    fl = 1; m_und = 1;
                end else begin
                    e = m_q.pop_front();
                    d = sx(dn) - e;
                    if (d < 0) d = -d;
                    fl = (d > TOL);
                end
            end
            if (ev) begin
                if (rdy) m_q.push_back(sx(ed));
                else m_ovf = 1;
            end
            m_mis = chk && fl;
            if (chk) begin
                if (fl) begin
                    if (m_err < 65535) m_err++;
                    if (m_first == 65535) m_first = m_samp;
                end
                m_samp++;
                if (m_samp == NSAMP) begin
                    m_run = 0; m_done = 1;
                end
            end else if (s && !m_run && !m_done) begin
                m_run = 1;
            end
        end
        @(posedge clk);
        #1;
        start = 0; rst = 0; bus.EXP_VALID = 0; bus.VIN = 0;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if (mismatch !== 1'b0) begin
            failures++; $display("FAIL reset_mismatch got=%b want=0", mismatch);
        end
        checks++;
        if (err_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_err_cnt got=%h want=0000", err_cnt);
        end
        checks++;
        if (samp_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_samp_cnt got=%h want=0000", samp_cnt);
        end
        checks++;
        if (first_err_idx !== 16'hFFFF) begin
            failures++; $display("FAIL reset_first got=%h want=ffff", first_err_idx);
        end
        checks++;
        if ({underrun, overflow, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {underrun, overflow, done});
        end
        checks++;
        if (bus.EXP_READY !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", bus.EXP_READY);
        end
    endtask

    task automatic test_clean_run();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(0, 1, i, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 1, i, 0);
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL clean_done_early got=%b want=0", done);
        end
        cyc(0, 0, 0, 1, 4, 0);
        checks++;
        if (done !== 1'b1 || samp_cnt !== 16'd4) begin
            failures++;
            $display("FAIL clean_done got=%b/%0d want=1/4", done, samp_cnt);
        end
        checks++;
        if (err_cnt !== 16'd0 || first_err_idx !== 16'hFFFF) begin
            failures++;
            $display("FAIL clean_err got=%0d/%h want=0/ffff", err_cnt, first_err_idx);
        end
        checks++;
        if (bus.EXP_READY !== 1'b0) begin
            failures++; $display("FAIL clean_ready_done got=%b want=0", bus.EXP_READY);
        end
    endtask

    task automatic test_signed_tol();
        int gold[3] = '{-128, 127, 5};
        int dins[3] = '{-127, 127, 7};
        int pulses = 0;
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, gold[i], 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, dins[i], 0);
            if (mismatch === 1'b1) pulses++;
        end
        checks++;
        if (mismatch !== 1'b1) begin
            failures++; $display("FAIL tol_mis_s2 got=%b want=1", mismatch);
        end
        cyc(0, 0, 0, 0, 0, 0);
        if (mismatch === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) begin
            failures++; $display("FAIL tol_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (err_cnt !== 16'd1 || first_err_idx !== 16'd2) begin
            failures++;
            $display("FAIL tol_err got=%0d/%0d want=1/2", err_cnt, first_err_idx);
        end
    endtask

    task automatic test_underrun();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        checks++;
        if (underrun !== 1'b1 || err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL underrun got=%b/%0d want=1/1", underrun, err_cnt);
        end
        checks++;
        if (first_err_idx !== 16'd0 || samp_cnt !== 16'd1) begin
            failures++;
            $display("FAIL underrun_idx got=%0d/%0d want=0/1", first_err_idx, samp_cnt);
        end
    endtask

    task automatic test_full();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, i, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.EXP_READY !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%b/%b want=0/0", bus.EXP_READY, overflow);
        end
        cyc(0, 1, 99, 1, 0, 0);
        checks++;
        if (overflow !== 1'b1 || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL full_ovf got=%b/%b want=1/0", overflow, mismatch);
        end
        checks++;
        if (dut.u_fifo.count !== 5'd15 || bus.EXP_READY !== 1'b1) begin
            failures++;
            $display("FAIL full_occ got=%0d/%b want=15/1", dut.u_fifo.count, bus.EXP_READY);
        end
    endtask

    task automatic test_reset_mid_run();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 10 * i, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 10 * i + 50, 0);
        checks++;
        if (err_cnt !== 16'd3) begin
            failures++; $display("FAIL mid_err got=%0d want=3", err_cnt);
        end
        cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if ({mismatch, underrun, overflow, done} !== 4'b0 || err_cnt !== 16'd0
            || samp_cnt !== 16'd0 || first_err_idx !== 16'hFFFF) begin
            failures++;
            $display("FAIL mid_rst got=%b%b%b%b/%0d/%0d/%h want=0000/0/0/ffff",
                     mismatch, underrun, overflow, done, err_cnt, samp_cnt, first_err_idx);
        end
        checks++;
        if (bus.EXP_READY !== 1'b1 || dut.st_q !== fir_chk_pkg::IDLE
            || dut.u_fifo.count !== 5'd0) begin
            failures++;
            $display("FAIL mid_state got=%b/%0d/%0d want=1/0/0",
                     bus.EXP_READY, dut.st_q, dut.u_fifo.count);
        end
        cyc(0, 0, 0, 1, 33, 0);
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (samp_cnt !== 16'd0 || err_cnt !== 16'd0 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL idle_vin got=%0d/%0d/%b want=0/0/0", samp_cnt, err_cnt, underrun);
        end
    endtask

    task automatic test_ignored();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, i, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 9, 0);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (samp_cnt !== 16'd2 || err_cnt !== 16'd1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ign_run got=%0d/%0d/%b want=2/1/0", samp_cnt, err_cnt, done);
        end
        cyc(0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 1, 3, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 77, 0);
        checks++;
        if (overflow !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL ign_done_pre got=%b/%b want=0/1", overflow, done);
        end
        cyc(0, 1, 5, 1, 77, 0);
        checks++;
        if (samp_cnt !== 16'd4 || err_cnt !== 16'd1 || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL ign_done got=%0d/%0d/%b want=4/1/0", samp_cnt, err_cnt, mismatch);
        end
        checks++;
        if (overflow !== 1'b1 || done !== 1'b1 || dut.u_fifo.count !== 5'd0) begin
            failures++;
            $display("FAIL ign_ovf got=%b/%b/%0d want=1/1/0", overflow, done, dut.u_fifo.count);
        end
    endtask

    task automatic test_random();
        logic [54:0] got, exp;
        bit s, ev, v, r;
        int ed, dn;
        for (int round = 0; round < 20; round++) begin
            cyc(0, 0, 0, 0, 0, 1);
            for (int c = 0; c < 40; c++) begin
                s  = ($urandom_range(0, 5) == 0);
                ev = $urandom_range(0, 1) == 1;
                v  = $urandom_range(0, 1) == 1;
                r  = ($urandom_range(0, 79) == 0);
                ed = int'($urandom_range(0, 255));
                if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                    dn = m_q[0] + int'($urandom_range(0, 4)) - 2;
                else
                    dn = int'($urandom_range(0, 255));
                cyc(s, ev, ed, v, dn, r);
                got = {mismatch, underrun, overflow, done, bus.EXP_READY,
                       2'b00, err_cnt, samp_cnt, first_err_idx};
                exp = {m_mis, m_und, m_ovf, m_done, m_ready(),
                       2'b00, 16'(m_err), 16'(m_samp), 16'(m_first)};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL random r%0d c%0d got=%h want=%h", round, c, got, exp);
                end
            end
        end
    endtask

    initial begin
        bus.EXP_VALID = 0; bus.EXP_DATA = '0; bus.VIN = 0; bus.DIN = '0;
        model_reset();
        test_reset();
        test_clean_run();
        test_signed_tol();
        test_underrun();
        test_full();
        test_reset_mid_run();
        test_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
